branch_cond_unit: RTL and testbench
===================================

# branch_cond_unit

Sequential consumer of the ALU status outputs (Negative, Zero, Carry, OverFlow). It holds the architectural NZCV flag register, evaluates 4-bit condition codes for branch instructions, and returns the taken/not-taken decision and target to fetch over a valid/ready handshake. After a taken branch it drives a timed pipeline flush. It sits between the execute stage (ALU flags in) and the fetch/PC logic (branch decision out).

## Interface
- FLUSH_CYCLES, 2: cycles `flush` stays high after a taken branch is handed off; 0..15 allowed.
- ADDR_W, 32: branch target width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  unit can accept; high only in IDLE.
- flag_we  in  1  instruction writes NZCV.
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU Negative/Zero/Carry/OverFlow for this instruction.
- is_branch  in  1  instruction is a conditional branch.
- cond  in  4  condition code.
- target  in  ADDR_W  branch destination.
- flags_q  out  4  registered {N,Z,C,V}.
- br_valid  out  1  branch decision available.
- br_ready  in  1  fetch consumes the decision.
- br_taken  out  1  condition passed.
- br_target  out  ADDR_W  registered target.
- flush  out  1  squash younger instructions.

## Operation
- Accept = in_valid & in_ready. Inputs are ignored otherwise.
- Flag update: on accept with flag_we=1, flags_q <= {alu_n,alu_z,alu_c,alu_v}. flag_we=0 leaves flags_q unchanged.
- Condition table (F = evaluated flags): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 reserved: always 0 (never taken; decision is still issued).
- Evaluated flags: by default, flags_q as it was before this accept. An instruction with both is_branch and flag_we set evaluates the old flags and then updates them.
- FSM, 3 states:
  - IDLE: in_ready=1. Accept with is_branch=1 registers br_taken, br_target and goes to RESP. Accept without a branch stays in IDLE.
  - RESP: br_valid=1; br_taken/br_target stable until br_ready. On br_ready: taken and FLUSH_CYCLES>0 goes to FLUSH with counter=FLUSH_CYCLES-1; otherwise goes to IDLE.
  - FLUSH: flush=1. Counter decrements each cycle; at counter==0 goes to IDLE.
- br_target width is exactly ADDR_W; no arithmetic on the target.

## Timing
- Reset values: flags_q=0000, state IDLE, br_valid=0, br_taken=0, br_target=0, flush=0, flush counter 0. in_ready=1 while in IDLE, including during reset.
- Branch accepted at edge t: br_valid=1 from cycle t+1.
- Handshake at edge h (br_valid & br_ready): br_valid=0 and flush=1 from h+1. flush stays high for exactly FLUSH_CYCLES cycles. in_ready returns in the cycle after the last flush cycle.
- Not-taken branch: in_ready=1 in the cycle after the handshake. Branch-to-branch throughput with br_ready tied high is one branch per 2 cycles.
- The flag update is visible on flags_q one cycle after the accept.
- br_ready held low: the unit stalls indefinitely in RESP with outputs stable.
- rst_n low mid-RESP or mid-FLUSH: everything returns immediately to the reset values, and no partial flush continues.

## Configuration
- COND_FLAG_BYPASS_EN defined: an accept with is_branch=1 and flag_we=1 evaluates cond against the incoming alu_* flags (fused compare-and-branch). flags_q is still updated.
- COND_FLAG_BYPASS_EN undefined: the old-flag behaviour above.
- Non-fused instructions behave identically in both builds.

## Structure
- Package cond_pkg holds:
  - cond_e, the 4-bit enum EQ..AL plus reserved NV=15.
  - state_e {IDLE, RESP, FLUSH}.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_eval: purely combinational, inputs {flags[3:0], cond[3:0]}, output pass. It is instantiated once inside branch_cond_unit.

## Test plan
- Reset, then flag_we with N,Z,C,V=0,1,0,0 -> flags_q=0100 next cycle. Then branch cond=EQ, target=0x100 -> br_valid=1, br_taken=1, br_target=0x100. br_ready=1 -> flush high exactly 2 cycles, then in_ready=1.
- flags_q=0000, branch cond=NE then cond=15 (br_ready high) -> first taken with flush, second br_taken=0 with no flush.
- flags N=1,V=0: branches LT, GE, GT, LE -> taken 1,0,0,1.
- Accept with is_branch=1, flag_we=1, alu_z=1 while flags_q Z=0, cond=EQ -> br_taken=0 without the macro, 1 with COND_FLAG_BYPASS_EN. flags_q Z=1 afterwards in both builds.
- br_ready held low for 5 cycles -> br_valid, br_taken, br_target stable and in_ready=0 throughout, with in_valid pulses ignored.
- rst_n asserted during the 2nd flush cycle -> flush=0 and flags_q=0000 immediately, and in_ready=1.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the branch condition unit: condition codes, FSM states
// and the bit positions of N, Z, C, V inside the 4-bit flag word.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit condition
// passes against an {N,Z,C,V} flag word. Code 15 is reserved and never passes.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [3:0] i_cond,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // NOTE: a default assignment before the case keeps this block free of latches.
    always_comb begin
        o_pass = 1'b0;
        case (cond_e'(i_cond))
            EQ: o_pass = w_z;
            NE: o_pass = !w_z;
            CS: o_pass = w_c;
            CC: o_pass = !w_c;
            MI: o_pass = w_n;
            PL: o_pass = !w_n;
            VS: o_pass = w_v;
            VC: o_pass = !w_v;
            HI: o_pass = w_c && !w_z;
            LS: o_pass = !w_c || w_z;
            GE: o_pass = (w_n == w_v);
            LT: o_pass = (w_n != w_v);
            GT: o_pass = !w_z && (w_n == w_v);
            LE: o_pass = w_z || (w_n != w_v);
            AL: o_pass = 1'b1;
            NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// NZCV flag register plus branch decision FSM (IDLE/RESP/FLUSH) with a timed flush.
// Optional COND_FLAG_BYPASS_EN: fused flag-write branches evaluate the incoming ALU flags.
module branch_cond_unit
    import cond_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flag_we,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              is_branch,
    input  logic [3:0]        cond,
    input  logic [ADDR_W-1:0] target,
    output logic [3:0]        flags_q,
    output logic              br_valid,
    input  logic              br_ready,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target,
    output logic              flush
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES > 0 ? FLUSH_CYCLES - 1 : 0);

    state_e            r_state;
    logic [3:0]        r_flags;
    logic [3:0]        r_cnt;
    logic              r_br_taken;
    logic [ADDR_W-1:0] r_br_target;

    logic [3:0] w_alu_flags;
    logic [3:0] w_eval_flags;
    logic       w_pass;
    logic       w_accept;

    always_comb begin
        w_alu_flags         = 4'b0000;
        w_alu_flags[FLAG_N] = alu_n;
        w_alu_flags[FLAG_Z] = alu_z;
        w_alu_flags[FLAG_C] = alu_c;
        w_alu_flags[FLAG_V] = alu_v;
    end

`ifdef COND_FLAG_BYPASS_EN
    // Fused compare-and-branch sees the flags it is writing this cycle.
    assign w_eval_flags = flag_we ? w_alu_flags : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    cond_eval u_cond_eval (
        .i_flags (w_eval_flags),
        .i_cond  (cond),
        .o_pass  (w_pass)
    );

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && in_ready;
    assign br_valid  = (r_state == RESP);
    assign flush     = (r_state == FLUSH);
    assign flags_q   = r_flags;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;

    // NOTE: all state uses non-blocking assignments and an asynchronous
    // active-low reset, so a mid-flush reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flags     <= 4'b0000;
            r_cnt       <= 4'd0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (flag_we) begin
                            r_flags <= w_alu_flags;
                        end
                        if (is_branch) begin
                            r_br_taken  <= w_pass;
                            r_br_target <= target;
                            r_state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (br_ready) begin
                        if (r_br_taken && (FLUSH_CYCLES > 0)) begin
                            r_state <= FLUSH;
                            r_cnt   <= FLUSH_INIT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: condition table vectors, fused
// flag-write branch, RESP stall and reset during flush.
module tb_branch_cond_unit;
    import cond_pkg::*;

    localparam int FLUSH_CYCLES = 2;
    localparam int ADDR_W       = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              flag_we;
    logic              alu_n, alu_z, alu_c, alu_v;
    logic              is_branch;
    logic [3:0]        cond;
    logic [ADDR_W-1:0] target;
    logic [3:0]        flags_q;
    logic              br_valid;
    logic              br_ready;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              flush;

    int n_checks = 0;
    int n_errors = 0;

    branch_cond_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flag_we   (flag_we),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .is_branch (is_branch),
        .cond      (cond),
        .target    (target),
        .flags_q   (flags_q),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_taken  (br_taken),
        .br_target (br_target),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       taken;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one instruction for a single edge.
    task automatic accept(input logic we, input logic [3:0] f, input logic br,
                          input logic [3:0] c, input logic [31:0] tgt);
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_wait: in_ready never rose within 50 cycles");
        end
        in_valid  = 1'b1;
        flag_we   = we;
        {alu_n, alu_z, alu_c, alu_v} = f;
        is_branch = br;
        cond      = c;
        target    = tgt;
        tick();
        in_valid  = 1'b0;
        flag_we   = 1'b0;
        is_branch = 1'b0;
    endtask

    // Hands off the pending decision and measures how long flush stays high.
    task automatic handshake(input string name, input logic exp_taken);
        int cnt = 0;
        br_ready = 1'b1;
        tick();
        br_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(br_valid), 32'd0);
        while (flush && cnt < 20) begin
            cnt++;
            tick();
        end
        check({name, "_flush_len"}, cnt, exp_taken ? FLUSH_CYCLES : 0);
        check({name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic exp_fused;

        vecs[0]  = '{4'b0100, EQ, 1'b1};
        vecs[1]  = '{4'b0000, NE, 1'b1};
        vecs[2]  = '{4'b0000, NV, 1'b0};
        vecs[3]  = '{4'b1000, LT, 1'b1};
        vecs[4]  = '{4'b1000, GE, 1'b0};
        vecs[5]  = '{4'b1000, GT, 1'b0};
        vecs[6]  = '{4'b1000, LE, 1'b1};
        vecs[7]  = '{4'b0010, CS, 1'b1};
        vecs[8]  = '{4'b0000, CC, 1'b1};
        vecs[9]  = '{4'b0010, HI, 1'b1};
        vecs[10] = '{4'b0110, HI, 1'b0};
        vecs[11] = '{4'b0110, LS, 1'b1};
        vecs[12] = '{4'b0001, VS, 1'b1};
        vecs[13] = '{4'b0001, VC, 1'b0};
        vecs[14] = '{4'b1000, MI, 1'b1};
        vecs[15] = '{4'b1000, PL, 1'b0};
        vecs[16] = '{4'b0000, AL, 1'b1};
        vecs[17] = '{4'b1001, GE, 1'b1};
        vecs[18] = '{4'b1001, GT, 1'b1};
        vecs[19] = '{4'b1001, LT, 1'b0};
        vecs[20] = '{4'b0101, LE, 1'b1};
        vecs[21] = '{4'b0100, NE, 1'b0};
        vecs[22] = '{4'b0010, LS, 1'b0};
        vecs[23] = '{4'b1111, NV, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; flag_we = 1'b0; is_branch = 1'b0;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        cond = 4'd0; target = '0; br_ready = 1'b0;

        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flags", 32'(flags_q), 32'd0);
        check("rst_br_valid", 32'(br_valid), 32'd0);
        check("rst_br_taken", 32'(br_taken), 32'd0);
        check("rst_br_target", br_target, 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            logic [31:0] tgt;
            tgt = 32'h100 + 32'(i * 16);
            accept(1'b1, vecs[i].flags, 1'b0, 4'd0, 32'd0);
            check($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vecs[i].flags));
            accept(1'b0, 4'b0000, 1'b1, vecs[i].cond, tgt);
            check($sformatf("v%0d_br_valid", i), 32'(br_valid), 32'd1);
            check($sformatf("v%0d_br_taken", i), 32'(br_taken), 32'(vecs[i].taken));
            check($sformatf("v%0d_br_target", i), br_target, tgt);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
            handshake($sformatf("v%0d", i), vecs[i].taken);
        end

        // Fused flag-write branch: old Z=0 vs incoming Z=1, cond EQ.
`ifdef COND_FLAG_BYPASS_EN
        exp_fused = 1'b1;
`else
        exp_fused = 1'b0;
`endif
        accept(1'b1, 4'b0000, 1'b0, 4'd0, 32'd0);
        accept(1'b1, 4'b0100, 1'b1, EQ, 32'h0000_0200);
        check("fused_taken", 32'(br_taken), 32'(exp_fused));
        check("fused_flags", 32'(flags_q), 32'b0100);
        handshake("fused", exp_fused);

        // br_ready held low: decision stays put, new instructions ignored.
        accept(1'b1, 4'b0000, 1'b0, 4'd0, 32'd0);
        accept(1'b0, 4'b0000, 1'b1, AL, 32'hDEAD_BEEC);
        for (int i = 0; i < 5; i++) begin
            in_valid  = i[0];
            flag_we   = 1'b1;
            is_branch = 1'b1;
            {alu_n, alu_z, alu_c, alu_v} = 4'b1111;
            cond      = NV;
            target    = 32'h0000_0004;
            tick();
            check($sformatf("stall%0d_valid", i), 32'(br_valid), 32'd1);
            check($sformatf("stall%0d_taken", i), 32'(br_taken), 32'd1);
            check($sformatf("stall%0d_target", i), br_target, 32'hDEAD_BEEC);
            check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; flag_we = 1'b0; is_branch = 1'b0;
        check("stall_flags_kept", 32'(flags_q), 32'd0);
        handshake("stall", 1'b1);

        // Reset asserted in the second flush cycle.
        accept(1'b1, 4'b1111, 1'b0, 4'd0, 32'd0);
        accept(1'b0, 4'b0000, 1'b1, AL, 32'h0000_0300);
        br_ready = 1'b1;
        tick();
        br_ready = 1'b0;
        check("rstf_flush1", 32'(flush), 32'd1);
        tick();
        check("rstf_flush2", 32'(flush), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstf_flush", 32'(flush), 32'd0);
        check("rstf_flags", 32'(flags_q), 32'd0);
        check("rstf_in_ready", 32'(in_ready), 32'd1);
        check("rstf_br_valid", 32'(br_valid), 32'd0);
        check("rstf_br_target", br_target, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstf_no_resume", 32'(flush), 32'd0);
        check("rstf_idle", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
